// File: rtl/iwishbone_mem_responder.sv
// Wishbone B4 classic instruction-memory responder with programmable wait states.
// Define IWB_RESP_PREFETCH_EN to add a one-word sequential prefetch buffer.
module iwishbone_mem_responder #(
  parameter int          MEM_ADDR_W  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [29:0]           wb_adr,
  input  logic [3:0]            wb_sel,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  inv,
  output logic                  busy
);

  localparam int                TAG_W    = 30 - MEM_ADDR_W;
  localparam logic [TAG_W-1:0]  BASE_TAG = BASE_ADDR[31:MEM_ADDR_W+2];
  localparam logic [3:0]        WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef IWB_RESP_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, WAIT, READ, RESP, ERR, PF_ISSUE, PF_CAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT, READ, RESP, ERR} state_t;
`endif

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  mem_en_c;
  logic [MEM_ADDR_W-1:0] mem_addr_c;
  logic                  req;

  function automatic logic in_range(input logic [29:0] a);
    return a[29:MEM_ADDR_W] == BASE_TAG;
  endfunction

  assign req = wb_cyc & wb_stb;

`ifdef IWB_RESP_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic [29:0] pf_addr_q, pf_addr_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic [29:0] adr_q, adr_d;
  logic [29:0] pf_nxt;
  logic        pf_hit;
  logic        unused_ok;

  assign pf_nxt    = adr_q + 30'd1;
  assign pf_hit    = pf_valid_q & ~inv & ~wb_we & (wb_adr == pf_addr_q);
  assign unused_ok = ^wb_sel;
`else
  logic unused_ok;
  assign unused_ok = ^{wb_sel, inv};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dat_d      = dat_q;
    mem_en_c   = 1'b0;
    mem_addr_c = wb_adr[MEM_ADDR_W-1:0];
`ifdef IWB_RESP_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    adr_d      = adr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (wb_we | ~in_range(wb_adr)) begin
            state_d = ERR;
`ifdef IWB_RESP_PREFETCH_EN
          end else if (pf_hit) begin
            dat_d   = pf_data_q;
            state_d = RESP;
`endif
          end else if (WAIT_STATES == 0) begin
            mem_en_c = 1'b1;
            state_d  = READ;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          mem_en_c = 1'b1;
          state_d  = READ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ: begin
        // Dropping cyc here discards the SRAM word already fetched.
        if (!wb_cyc) begin
          state_d = IDLE;
        end else begin
          dat_d   = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef IWB_RESP_PREFETCH_EN
        if (in_range(pf_nxt)) state_d = PF_ISSUE;
`endif
      end
      ERR: state_d = IDLE;
`ifdef IWB_RESP_PREFETCH_EN
      PF_ISSUE: begin
        mem_en_c   = 1'b1;
        mem_addr_c = pf_nxt[MEM_ADDR_W-1:0];
        state_d    = PF_CAP;
      end
      PF_CAP: begin
        pf_data_d  = mem_rdata;
        pf_addr_d  = pf_nxt;
        pf_valid_d = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef IWB_RESP_PREFETCH_EN
    if (state_q == IDLE && req) begin
      adr_d = wb_adr;
      if (!pf_hit) pf_valid_d = 1'b0;
    end
    // Invalidation wins over a capture landing in the same cycle.
    if (inv) pf_valid_d = 1'b0;
`endif
    ack_d = (state_d == RESP);
    err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef IWB_RESP_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pf_valid_q <= 1'b0;
    else     pf_valid_q <= pf_valid_d;
  end

  always_ff @(posedge clk) begin
    pf_addr_q <= pf_addr_d;
    pf_data_q <= pf_data_d;
    adr_q     <= adr_d;
  end
`endif

  assign wb_dat_o = dat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign mem_en   = mem_en_c & ~rst;
  assign mem_addr = mem_addr_c;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_iwishbone_mem_responder.sv
// Fetch-unit bus model for iwishbone_mem_responder: two responders (0 and 3 wait
// states) share one SRAM image; expectations are queued and checked on response.
module tb_iwishbone_mem_responder;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    cyc, stb, we, inv, mem_en, ack, err, busy;
  logic [29:0]   adr   [2];
  logic [3:0]    sel   [2];
  logic [31:0]   dat   [2];
  logic [31:0]   rdata [2];
  logic [AW-1:0] maddr [2];
  logic [31:0]   sram  [0:4095];

  typedef struct { logic [31:0] dat; logic err; int lat; } exp_t;
  typedef struct {
    logic o_ack; logic o_err; logic extra; logic both; logic [31:0] dat;
    int lat; int men_first; int men_cnt; int busy_cnt;
  } obs_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

`ifdef IWB_RESP_PREFETCH_EN
  localparam int B2B_GAP = 5;
`else
  localparam int B2B_GAP = 3;
`endif

  iwishbone_mem_responder #(.MEM_ADDR_W(AW), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_adr(adr[0]),
    .wb_sel(sel[0]), .wb_dat_o(dat[0]), .wb_ack(ack[0]), .wb_err(err[0]), .mem_en(mem_en[0]),
    .mem_addr(maddr[0]), .mem_rdata(rdata[0]), .inv(inv[0]), .busy(busy[0]));

  iwishbone_mem_responder #(.MEM_ADDR_W(AW), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_adr(adr[1]),
    .wb_sel(sel[1]), .wb_dat_o(dat[1]), .wb_ack(ack[1]), .wb_err(err[1]), .mem_en(mem_en[1]),
    .mem_addr(maddr[1]), .mem_rdata(rdata[1]), .inv(inv[1]), .busy(busy[1]));

  always @(posedge clk) begin
    if (mem_en[0]) rdata[0] <= sram[maddr[0]];
    if (mem_en[1]) rdata[1] <= sram[maddr[1]];
  end

  function automatic logic [31:0] word_of(input int k);
    return (k == 16) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(k));
  endfunction

  task automatic wait_idle(input int i);
    int k = 0;
    @(negedge clk);
    while (busy[i] !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic issue(input int i, input logic [29:0] a, input logic w, output obs_t o);
    o = '{default: 0};
    o.lat = -1;
    o.men_first = -1;
    wait_idle(i);
    @(posedge clk); #1;
    adr[i] = a; we[i] = w; sel[i] = 4'hF; cyc[i] = 1'b1; stb[i] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_en[i]) begin
        if (o.men_cnt == 0) o.men_first = c;
        o.men_cnt++;
      end
      if (busy[i]) o.busy_cnt++;
      if (ack[i] & err[i]) o.both = 1'b1;
      if (ack[i] | err[i]) begin
        o.o_ack = ack[i]; o.o_err = err[i]; o.dat = dat[i]; o.lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    @(negedge clk);
    o.extra = ack[i] | err[i];
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ack, err, busy, mem_en} !== 8'h00)
      $display("FAIL reset_ctrl: got ack=%b err=%b busy=%b mem_en=%b want all 0", ack, err, busy, mem_en);
    else passed++;
    total++;
    if ({dat[0], dat[1]} !== 64'h0)
      $display("FAIL reset_dat: got %h %h want 0", dat[0], dat[1]);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_read(input string nm, input int i, input logic [29:0] a, input int exp_men);
    exp_t e;
    obs_t o;
    sb.push_back('{word_of(int'(a[AW-1:0])), 1'b0, (i == 0) ? 2 : 5});
    issue(i, a, 1'b0, o);
    e = sb.pop_front();
    total++;
    if ({o.o_ack, o.o_err, o.dat} !== {1'b1, 1'b0, e.dat})
      $display("FAIL %s resp: got ack=%b err=%b dat=%h want ack=1 err=0 dat=%h", nm, o.o_ack, o.o_err, o.dat, e.dat);
    else passed++;
    total++;
    if (o.lat !== e.lat)
      $display("FAIL %s latency: got %0d want %0d", nm, o.lat, e.lat);
    else passed++;
    total++;
    if (o.men_first !== exp_men || o.men_cnt !== 1 || o.busy_cnt !== e.lat || o.extra || o.both)
      $display("FAIL %s timing: got mem_en@%0d x%0d busy=%0d extra=%b both=%b want mem_en@%0d x1 busy=%0d extra=0 both=0",
               nm, o.men_first, o.men_cnt, o.busy_cnt, o.extra, o.both, exp_men, e.lat);
    else passed++;
  endtask

  task automatic test_error(input string nm, input int i, input logic [29:0] a, input logic w);
    exp_t e;
    obs_t o;
    sb.push_back('{dat[i], 1'b1, 1});
    issue(i, a, w, o);
    e = sb.pop_front();
    total++;
    if ({o.o_ack, o.o_err, o.dat} !== {1'b0, 1'b1, e.dat} || o.lat !== e.lat)
      $display("FAIL %s resp: got ack=%b err=%b dat=%h lat=%0d want ack=0 err=1 dat=%h lat=%0d",
               nm, o.o_ack, o.o_err, o.dat, o.lat, e.dat, e.lat);
    else passed++;
    total++;
    if (o.men_cnt !== 0 || o.extra || o.both || o.busy_cnt !== 1)
      $display("FAIL %s pulse: got mem_en x%0d extra=%b both=%b busy=%0d want 0 0 0 1",
               nm, o.men_cnt, o.extra, o.both, o.busy_cnt);
    else passed++;
  endtask

  task automatic test_abort();
    logic b1, b2, resp, men;
    wait_idle(1);
    @(posedge clk); #1;
    adr[1] = 30'h2000_0001; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    b1 = busy[1]; resp = ack[1] | err[1]; men = mem_en[1];
    @(negedge clk);
    b2 = busy[1]; resp |= ack[1] | err[1]; men |= mem_en[1];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      resp |= ack[1] | err[1];
      men  |= mem_en[1];
    end
    total++;
    if ({b1, b2} !== 2'b10)
      $display("FAIL abort_busy: got cycle1=%b cycle2=%b want 1 0", b1, b2);
    else passed++;
    total++;
    if (resp !== 1'b0 || men !== 1'b0)
      $display("FAIL abort_quiet: got resp=%b mem_en=%b want 0 0", resp, men);
    else passed++;
    test_read("abort_then_read", 1, 30'h2000_0004, 3);
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    int first, second;
    logic [31:0] d1, d2;
    sb.push_back('{word_of(32), 1'b0, 2});
    sb.push_back('{word_of(48), 1'b0, B2B_GAP});
    first = -1; second = -1; d1 = '0; d2 = '0;
    wait_idle(0);
    @(posedge clk); #1;
    adr[0] = 30'h2000_0020; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        if (first < 0) begin
          first = c; d1 = dat[0];
          @(posedge clk); #1;
          adr[0] = 30'h2000_0030;
        end else begin
          second = c; d2 = dat[0];
          break;
        end
      end
    end
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    total++;
    if (first !== e1.lat || d1 !== e1.dat)
      $display("FAIL b2b_first: got lat=%0d dat=%h want lat=%0d dat=%h", first, d1, e1.lat, e1.dat);
    else passed++;
    total++;
    if (second - first !== e2.lat || d2 !== e2.dat)
      $display("FAIL b2b_second: got gap=%0d dat=%h want gap=%0d dat=%h", second - first, d2, e2.lat, e2.dat);
    else passed++;
  endtask

`ifdef IWB_RESP_PREFETCH_EN
  task automatic test_prefetch();
    exp_t e;
    obs_t o;
    for (int n = 0; n < 3; n++) begin
      sb.push_back('{word_of(n), 1'b0, (n == 1) ? 1 : 2});
      if (n == 2) begin
        @(posedge clk); #1 inv[0] = 1'b1;
        @(posedge clk); #1 inv[0] = 1'b0;
      end
      issue(0, 30'h2000_0000 + 30'(n), 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o.o_ack !== 1'b1 || o.dat !== e.dat || o.lat !== e.lat || o.extra)
        $display("FAIL prefetch_read%0d: got ack=%b dat=%h lat=%0d extra=%b want ack=1 dat=%h lat=%0d extra=0",
                 n, o.o_ack, o.dat, o.lat, o.extra, e.dat, e.lat);
      else passed++;
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    logic resp;
    wait_idle(0);
    @(posedge clk); #1;
    adr[0] = 30'h2000_0010; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({ack[0], err[0], busy[0], mem_en[0]} !== 4'b0000 || dat[0] !== 32'h0)
      $display("FAIL reset_mid_read: got ack=%b err=%b busy=%b mem_en=%b dat=%h want all 0",
               ack[0], err[0], busy[0], mem_en[0], dat[0]);
    else passed++;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      resp |= ack[0] | err[0] | busy[0];
    end
    total++;
    if (resp !== 1'b0)
      $display("FAIL reset_release_quiet: got activity=%b want 0", resp);
    else passed++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; inv = '0;
    adr[0] = '0; adr[1] = '0; sel[0] = '0; sel[1] = '0;
    for (int k = 0; k < 4096; k++) sram[k] = word_of(k);
    test_reset();
    test_read("ws0_read", 0, 30'h2000_0010, 0);
    test_read("ws0_last_word", 0, 30'h2000_0FFF, 0);
    test_read("ws3_read", 1, 30'h2000_0001, 3);
    test_error("err_range", 0, 30'h2000_1000, 1'b0);
    test_error("err_write", 0, 30'h2000_0000, 1'b1);
    test_error("err_write_ws3", 1, 30'h2000_0000, 1'b1);
    test_abort();
    test_back_to_back();
`ifdef IWB_RESP_PREFETCH_EN
    test_prefetch();
`endif
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
